// File: rtl/capnet_mac_top.sv
`default_nettype none
// ============================================================================
// Module   : capnet_mac_top
// Function : Multi-mode streaming multiply-accumulate (dot8/dot16/sqnorm/
//            scale/colsum) with a saturated 24-bit result and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module capnet_mac_top #(
    parameter int IN_SIZE  = 19,
    parameter int OUT_SIZE = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sq,
    input  logic                sc,
    input  logic                mat8,
    input  logic                mat16,
    input  logic                col_sum,
    input  logic [IN_SIZE:0]    in1,
    input  logic [IN_SIZE:0]    in2,
    output logic [OUT_SIZE:0]   out,
    output logic                done
);

    localparam int PW    = 2 * (IN_SIZE + 1);
    localparam int ACC_W = 48;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic signed [ACC_W-1:0] c_SAT_MAX = (48'sd1 <<< OUT_SIZE) - 48'sd1;
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = -(48'sd1 <<< OUT_SIZE);

    logic [0:0]               r_state;
    logic [3:0]               r_cnt;
    logic [3:0]               r_last;
    logic                     r_sq;
    logic                     r_col;
    logic signed [ACC_W-1:0]  r_acc;
    logic [OUT_SIZE:0]        r_out;
    logic                     r_done;

    logic                     w_start;
    logic                     w_cmd_col;
    logic [3:0]               w_cmd_last;
    logic                     w_sel_sq;
    logic                     w_sel_col;
    logic [3:0]               w_sel_last;
    logic [3:0]               w_cnt;
    logic                     w_final;
    logic signed [IN_SIZE:0]  w_mul_b;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_sum;
    logic [OUT_SIZE:0]        w_sat;

    assign w_start = (r_state == S_IDLE) && (sq || sc || mat8 || mat16 || col_sum);

    // Priority sq > sc > mat8 > mat16 > col_sum; encoded as index of last sample.
    always_comb begin
        w_cmd_col  = 1'b0;
        w_cmd_last = 4'd7;
        if (sq)         w_cmd_last = 4'd15;
        else if (sc)    w_cmd_last = 4'd0;
        else if (mat8)  w_cmd_last = 4'd7;
        else if (mat16) w_cmd_last = 4'd15;
        else            w_cmd_col  = 1'b1;
    end

    // On the start edge the fresh command decides; afterwards the latched mode.
    assign w_sel_sq   = w_start ? sq         : r_sq;
    assign w_sel_col  = w_start ? w_cmd_col  : r_col;
    assign w_sel_last = w_start ? w_cmd_last : r_last;
    assign w_cnt      = w_start ? 4'd0       : r_cnt;
    assign w_final    = (w_cnt == w_sel_last);

    assign w_mul_b = w_sel_sq ? $signed(in1) : $signed(in2);
    assign w_prod  = $signed(in1) * w_mul_b;
    assign w_term  = w_sel_col ? {{(ACC_W-IN_SIZE-1){in1[IN_SIZE]}}, in1}
                               : {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    assign w_sum   = (w_start ? '0 : r_acc) + w_term;

    always_comb begin
        w_sat = w_sum[OUT_SIZE:0];
        if (w_sum > c_SAT_MAX)      w_sat = c_SAT_MAX[OUT_SIZE:0];
        else if (w_sum < c_SAT_MIN) w_sat = c_SAT_MIN[OUT_SIZE:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
            r_sq    <= 1'b0;
            r_col   <= 1'b0;
            r_acc   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start || (r_state == S_RUN)) begin
                if (w_start) begin
                    r_sq   <= sq;
                    r_col  <= w_cmd_col;
                    r_last <= w_cmd_last;
                end
                r_acc <= w_sum;
                r_cnt <= w_cnt + 4'd1;
                if (w_final) begin
                    r_out   <= w_sat;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    r_state <= S_RUN;
                end
            end
        end
    end

    assign out  = r_out;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_capnet_mac_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_capnet_mac_top
// Function : Self-checking bench: directed literal cases plus random traffic
//            against a sample-list reference model of the MAC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capnet_mac_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sq = 1'b0, sc = 1'b0, mat8 = 1'b0, mat16 = 1'b0, col_sum = 1'b0;
    logic [19:0] in1 = '0, in2 = '0;
    logic [23:0] out;
    logic        done;

    int checks = 0;
    int errors = 0;
    int a [0:15];
    int b [0:15];

    capnet_mac_top #(.IN_SIZE(19), .OUT_SIZE(23)) dut (
        .clk(clk), .rst(rst), .sq(sq), .sc(sc), .mat8(mat8), .mat16(mat16),
        .col_sum(col_sum), .in1(in1), .in2(in2), .out(out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: collect terms for N samples, sum exactly, clamp.
    bit     armed = 0;
    bit     m_busy = 0;
    int     m_mode = 0;
    int     m_n = 0;
    int     m_cnt = 0;
    longint m_acc = 0;
    longint m_out = 0;
    bit     m_done = 0;

    function automatic longint sat24(input longint v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    always @(posedge clk) begin
        longint x, y;
        x = longint'($signed(in1));
        y = longint'($signed(in2));
        if (rst) begin
            armed = 1; m_busy = 0; m_out = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                m_mode = -1;
                if (sq)           begin m_mode = 0; m_n = 16; end
                else if (sc)      begin m_mode = 1; m_n = 1;  end
                else if (mat8)    begin m_mode = 2; m_n = 8;  end
                else if (mat16)   begin m_mode = 3; m_n = 16; end
                else if (col_sum) begin m_mode = 4; m_n = 8;  end
                if (m_mode >= 0) begin m_busy = 1; m_acc = 0; m_cnt = 0; end
            end
            if (m_busy) begin
                case (m_mode)
                    0:       m_acc += x * x;
                    4:       m_acc += x;
                    default: m_acc += x * y;
                endcase
                m_cnt++;
                if (m_cnt == m_n) begin
                    m_out = sat24(m_acc); m_done = 1; m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk(longint'($signed(out)) == m_out, "model_out", longint'($signed(out)), m_out);
            chk(done === m_done, "model_done", longint'(done), longint'(m_done));
        end
    end

    task automatic run_op(input logic [4:0] c, input int hold, input int n,
                          input int exp_val, input string name);
        int  edges;
        bit  seen;
        @(negedge clk);
        {sq, sc, mat8, mat16, col_sum} = c;
        in1 = 20'(a[0]); in2 = 20'(b[0]);
        edges = 0; seen = 0;
        while (!seen && edges < 40) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (done) seen = 1;
            if (edges >= hold) {sq, sc, mat8, mat16, col_sum} = 5'b0;
            in1 = 20'(a[edges % 16]); in2 = 20'(b[edges % 16]);
        end
        chk(seen && edges == n, {name, "_latency"}, edges, n);
        chk(longint'($signed(out)) == exp_val, {name, "_out"}, longint'($signed(out)), exp_val);
    endtask

    task automatic idle_no_done(input int k, input string name);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk(done == 1'b0, name, longint'(done), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk(out == 24'd0, "reset_out", longint'(out), 0);
        chk(done == 1'b0, "reset_done", longint'(done), 0);

        // mat8 held two cycles, in1=in2=2..9 -> 284
        for (int i = 0; i < 16; i++) begin a[i] = i + 2; b[i] = i + 2; end
        run_op(5'b00100, 2, 8, 284, "mat8");
        idle_no_done(10, "mat8_single_done");

        for (int i = 0; i < 16; i++) begin a[i] = i + 2; b[i] = 1; end
        run_op(5'b00010, 1, 16, 152, "mat16");

        a[0] = -3; b[0] = 7;
        for (int i = 1; i < 16; i++) begin a[i] = 0; b[i] = 0; end
        run_op(5'b01000, 1, 1, -21, "sc");

        for (int i = 0; i < 16; i++) begin a[i] = 1000; b[i] = 0; end
        run_op(5'b10000, 1, 16, 8388607, "sq_satpos");

        for (int i = 0; i < 16; i++) begin a[i] = -2000; b[i] = 1000; end
        run_op(5'b00100, 1, 8, -8388608, "mat8_satneg");

        for (int i = 0; i < 16; i++) begin a[i] = 100 + (i % 8); b[i] = int'($urandom_range(0, 1000000)) - 500000; end
        run_op(5'b00001, 1, 8, 828, "colsum");
        for (int i = 0; i < 16; i++) b[i] = int'($urandom_range(0, 1000000)) - 500000;
        run_op(5'b00001, 1, 8, 828, "colsum_in2");

        for (int i = 0; i < 16; i++) begin a[i] = 3; b[i] = 5; end
        run_op(5'b10100, 1, 16, 144, "prio_sq");

        // Abort mat8 after four samples with reset
        for (int i = 0; i < 16; i++) begin a[i] = i + 2; b[i] = i + 2; end
        @(negedge clk);
        mat8 = 1'b1; in1 = 20'(a[0]); in2 = 20'(b[0]);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); @(negedge clk);
            mat8 = 1'b0; in1 = 20'(a[i]); in2 = 20'(b[i]);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk(out == 24'd0, "abort_out", longint'($signed(out)), 0);
        idle_no_done(12, "abort_no_done");
        for (int i = 0; i < 16; i++) begin a[i] = i + 2; b[i] = 1; end
        run_op(5'b00010, 1, 16, 152, "mat16_after_abort");

        // Random traffic: frequent commands for back-to-back starts, rare resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) < 4)
                {sq, sc, mat8, mat16, col_sum} = 5'($urandom_range(1, 31));
            else
                {sq, sc, mat8, mat16, col_sum} = 5'b0;
            if ($urandom_range(0, 3) == 0) begin
                in1 = 20'($urandom); in2 = 20'($urandom);
            end else begin
                in1 = 20'(int'($urandom_range(0, 2000)) - 1000);
                in2 = 20'(int'($urandom_range(0, 2000)) - 1000);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        {sq, sc, mat8, mat16, col_sum} = 5'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
